// File: rtl/card_pkg.sv
// Shared types and constants for the 6x6 memory-card board tracker.
package card_pkg;

    localparam int NUM_CELLS = 36;
    localparam int NUM_PAIRS = 18;
    localparam logic [5:0] NO_LOC = 6'h3F;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        REVEALED = 2'd1,
        MATCHED  = 2'd2
    } cell_state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ONE_UP = 2'd1,
        ST_JUDGE  = 2'd2,
        ST_HOLD   = 2'd3
    } tracker_state_t;

    function automatic logic loc_in_range(input logic [5:0] loc);
        return loc < 6'(NUM_CELLS);
    endfunction

endpackage

// File: rtl/reveal_timer.sv
// Loadable saturating down-counter shared by the compare wait and the reveal hold.
module reveal_timer #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] value,
    output logic         zero
);

    // Clear beats load, load beats count; the count stops at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (enable && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/card_board_tracker.sv
// Board state tracker for the card-matching game.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no card face-up, waiting for the first selection
//   ST_ONE_UP | first card face-up, waiting for a different second card
//   ST_JUDGE  | two cards up, waiting up to COMPARE_WAIT cycles for a match
//   ST_HOLD   | mismatch shown for REVEAL_CYCLES cycles, then both hidden
module card_board_tracker
    import card_pkg::*;
#(
    parameter int REVEAL_CYCLES = 50_000_000,
    parameter int COMPARE_WAIT  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_game,
    input  logic       sel_valid,
    input  logic [5:0] sel_loc,
    input  logic       pair_found,
    input  logic [5:0] pair_loc1,
    input  logic [5:0] pair_loc2,
    input  logic [5:0] rd_loc,
    output logic [1:0] rd_state,
    output logic       busy,
    output logic [5:0] first_loc,
    output logic [5:0] second_loc,
    output logic [4:0] matched_count,
    output logic       all_matched
);

    localparam int TW = 32;

    tracker_state_t state;
    cell_state_t    cells [NUM_CELLS];

    logic          tmr_clear;
    logic          tmr_load;
    logic [TW-1:0] tmr_load_value;
    logic          tmr_enable;
    logic [TW-1:0] tmr_value;
    logic          tmr_zero;

    logic [5:0] sel_idx;
    logic       sel_ok;
    logic       pair_hit;
    logic       wait_expired;

    reveal_timer #(.W(TW)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .enable     (tmr_enable),
        .value      (tmr_value),
        .zero       (tmr_zero)
    );

    // JUDGE is entered with COMPARE_WAIT loaded; leaving on the cycle that
    // shows 1 keeps the judge window exactly COMPARE_WAIT cycles long.
    assign wait_expired = (tmr_value <= TW'(1));

    assign sel_idx = loc_in_range(sel_loc) ? sel_loc : 6'd0;

    // Qualify selections and pair reports against the current board.
    always_comb begin
        sel_ok   = sel_valid && !all_matched && loc_in_range(sel_loc)
                   && (cells[sel_idx] == HIDDEN);
        pair_hit = pair_found
                   && (((pair_loc1 == first_loc) && (pair_loc2 == second_loc))
                    || ((pair_loc1 == second_loc) && (pair_loc2 == first_loc)));
    end

    // Timer control decoded from the current state and its inputs.
    always_comb begin
        tmr_clear      = new_game;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        tmr_enable     = 1'b0;
        case (state)
            ST_ONE_UP: begin
                if (sel_ok && (sel_loc != first_loc)) begin
                    tmr_load       = 1'b1;
                    tmr_load_value = TW'(COMPARE_WAIT);
                end
            end
            ST_JUDGE: begin
                if (pair_hit) begin
                    tmr_clear = 1'b1;
                end else if (wait_expired) begin
                    tmr_load       = 1'b1;
                    tmr_load_value = TW'(REVEAL_CYCLES - 1);
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            ST_HOLD:  tmr_enable = 1'b1;
            default:  ;
        endcase
    end

    // Main FSM: owns the cell array and every registered output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CELLS; i++) cells[i] <= HIDDEN;
            state         <= ST_IDLE;
            busy          <= 1'b0;
            first_loc     <= NO_LOC;
            second_loc    <= NO_LOC;
            matched_count <= '0;
            all_matched   <= 1'b0;
        end else if (new_game) begin
            for (int i = 0; i < NUM_CELLS; i++) cells[i] <= HIDDEN;
            state         <= ST_IDLE;
            busy          <= 1'b0;
            first_loc     <= NO_LOC;
            second_loc    <= NO_LOC;
            matched_count <= '0;
            all_matched   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_ok) begin
                        cells[sel_idx] <= REVEALED;
                        first_loc      <= sel_loc;
                        state          <= ST_ONE_UP;
                    end
                end
                ST_ONE_UP: begin
                    if (sel_ok && (sel_loc != first_loc)) begin
                        cells[sel_idx] <= REVEALED;
                        second_loc     <= sel_loc;
                        state          <= ST_JUDGE;
                        busy           <= 1'b1;
                    end
                end
                ST_JUDGE: begin
                    if (pair_hit) begin
                        cells[first_loc]  <= MATCHED;
                        cells[second_loc] <= MATCHED;
                        if (matched_count != 5'(NUM_PAIRS)) begin
                            matched_count <= matched_count + 5'd1;
                            all_matched   <= (matched_count == 5'(NUM_PAIRS - 1));
                        end
                        first_loc  <= NO_LOC;
                        second_loc <= NO_LOC;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                    end else if (wait_expired) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        cells[first_loc]  <= HIDDEN;
                        cells[second_loc] <= HIDDEN;
                        first_loc         <= NO_LOC;
                        second_loc        <= NO_LOC;
                        state             <= ST_IDLE;
                        busy              <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_state = loc_in_range(rd_loc) ? cells[rd_loc] : HIDDEN;

endmodule

// File: tb/tb_card_board_tracker.sv
// Directed scoreboard bench for card_board_tracker.
module tb_card_board_tracker;

    localparam int K_CELL   = 0;
    localparam int K_BUSY   = 1;
    localparam int K_FIRST  = 2;
    localparam int K_SECOND = 3;
    localparam int K_COUNT  = 4;
    localparam int K_ALL    = 5;

    typedef struct {
        int    kind;
        int    loc;
        int    exp;
        string tag;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       new_game = 1'b0;
    logic       sel_valid = 1'b0;
    logic [5:0] sel_loc = '0;
    logic       pair_found = 1'b0;
    logic [5:0] pair_loc1 = '0;
    logic [5:0] pair_loc2 = '0;
    logic [5:0] rd_loc = '0;
    logic [1:0] rd_state;
    logic       busy;
    logic [5:0] first_loc;
    logic [5:0] second_loc;
    logic [4:0] matched_count;
    logic       all_matched;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    card_board_tracker #(.REVEAL_CYCLES(8), .COMPARE_WAIT(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .new_game      (new_game),
        .sel_valid     (sel_valid),
        .sel_loc       (sel_loc),
        .pair_found    (pair_found),
        .pair_loc1     (pair_loc1),
        .pair_loc2     (pair_loc2),
        .rd_loc        (rd_loc),
        .rd_state      (rd_state),
        .busy          (busy),
        .first_loc     (first_loc),
        .second_loc    (second_loc),
        .matched_count (matched_count),
        .all_matched   (all_matched)
    );

    always #50 clock = ~clock;

    task automatic push(input int kind, input int loc, input int exp, input string tag);
        exp_t e;
        e.kind = kind; e.loc = loc; e.exp = exp; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_all_cells(input int exp, input string tag);
        for (int i = 0; i < 36; i++) push(K_CELL, i, exp, tag);
    endtask

    task automatic push_reset_outputs(input string tag);
        push(K_BUSY,   0, 0,  tag);
        push(K_FIRST,  0, 63, tag);
        push(K_SECOND, 0, 63, tag);
        push(K_COUNT,  0, 0,  tag);
        push(K_ALL,    0, 0,  tag);
        push_all_cells(0, tag);
    endtask

    // Called mid-cycle (after a falling edge); each cell query takes 1 time unit.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_CELL: begin
                    rd_loc = 6'(e.loc);
                    #1;
                    obs = {30'd0, rd_state};
                end
                K_BUSY:   obs = {31'd0, busy};
                K_FIRST:  obs = {26'd0, first_loc};
                K_SECOND: obs = {26'd0, second_loc};
                K_COUNT:  obs = {27'd0, matched_count};
                default:  obs = {31'd0, all_matched};
            endcase
            total++;
            assert (obs === 32'(e.exp)) else begin
                bad++;
                $error("FAIL %s kind=%0d loc=%0d observed=%0d expected=%0d",
                       e.tag, e.kind, e.loc, obs, e.exp);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic select(input int loc);
        sel_valid = 1'b1;
        sel_loc   = 6'(loc);
        @(negedge clock);
        sel_valid = 1'b0;
    endtask

    task automatic pair(input int a, input int b);
        pair_found = 1'b1;
        pair_loc1  = 6'(a);
        pair_loc2  = 6'(b);
        @(negedge clock);
        pair_found = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        push_reset_outputs("reset");
        push(K_CELL, 40, 0, "rd_out_of_range");
        drain();
        reset = 1'b0;
        cyc(1);

        // Match: 3 then 17, pair reported reversed on judge cycle 2
        select(3);
        push(K_FIRST, 0, 3, "match_first");
        push(K_CELL, 3, 1, "match_cell3_up");
        push(K_BUSY, 0, 0, "match_busy_one_up");
        drain();
        select(17);
        push(K_BUSY, 0, 1, "match_busy_judge");
        push(K_SECOND, 0, 17, "match_second");
        push(K_CELL, 17, 1, "match_cell17_up");
        drain();
        cyc(1);
        pair(17, 3);
        push(K_CELL, 3, 2, "match_cell3");
        push(K_CELL, 17, 2, "match_cell17");
        push(K_COUNT, 0, 1, "match_count");
        push(K_BUSY, 0, 0, "match_busy_after");
        push(K_FIRST, 0, 63, "match_first_clr");
        push(K_SECOND, 0, 63, "match_second_clr");
        drain();

        // Ignored selections, then mismatch with a stray pair and a HOLD selection
        select(5);
        select(5);
        select(40);
        select(3);
        push(K_FIRST, 0, 5, "ign_first");
        push(K_SECOND, 0, 63, "ign_second");
        push(K_BUSY, 0, 0, "ign_busy");
        push(K_CELL, 3, 2, "ign_matched_cell");
        drain();
        select(9);
        push(K_BUSY, 0, 1, "mis_busy_j1");
        drain();
        pair(1, 2);
        push(K_BUSY, 0, 1, "stray_busy");
        push(K_COUNT, 0, 1, "stray_count");
        drain();
        cyc(3);
        select(20);
        push(K_CELL, 20, 0, "hold_sel_cell");
        push(K_BUSY, 0, 1, "hold_sel_busy");
        push(K_SECOND, 0, 9, "hold_second");
        drain();
        cyc(6);
        push(K_BUSY, 0, 1, "mis_busy_last");
        push(K_CELL, 5, 1, "mis_cell5_up");
        drain();
        cyc(1);
        push(K_BUSY, 0, 0, "mis_busy_end");
        push(K_CELL, 5, 0, "mis_cell5_hidden");
        push(K_CELL, 9, 0, "mis_cell9_hidden");
        push(K_FIRST, 0, 63, "mis_first_clr");
        push(K_SECOND, 0, 63, "mis_second_clr");
        drain();
        pair(5, 9);
        push(K_COUNT, 0, 1, "idle_pair_count");
        push(K_CELL, 5, 0, "idle_pair_cell");
        drain();

        // Asynchronous reset on HOLD cycle 3
        select(5);
        select(9);
        cyc(6);
        push(K_BUSY, 0, 1, "hold3_busy");
        drain();
        #10;
        reset = 1'b1;
        #1;
        push_reset_outputs("async_reset");
        drain();
        @(negedge clock);
        reset = 1'b0;
        cyc(1);

        // Full game: pairs (2k, 2k+1)
        for (int k = 0; k < 18; k++) begin
            select(2 * k);
            select(2 * k + 1);
            pair(2 * k, 2 * k + 1);
            push(K_COUNT, 0, k + 1, "game_count");
            push(K_ALL, 0, (k == 17) ? 1 : 0, "game_all");
            drain();
        end
        push_all_cells(2, "game_cells");
        select(0);
        push(K_FIRST, 0, 63, "done_sel_first");
        push(K_BUSY, 0, 0, "done_sel_busy");
        push(K_COUNT, 0, 18, "done_count");
        drain();

        // new_game together with a selection: new_game wins
        new_game  = 1'b1;
        sel_valid = 1'b1;
        sel_loc   = 6'd4;
        @(negedge clock);
        new_game  = 1'b0;
        sel_valid = 1'b0;
        push_reset_outputs("new_game");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/card_board_tracker.md
CARD_BOARD_TRACKER -- requirements
Module: card_board_tracker

Interface
REQ-001 Parameter REVEAL_CYCLES, default 50_000_000, mismatched-pair display time in clock cycles (1 s at 50 MHz).
REQ-002 Parameter COMPARE_WAIT, default 4, maximum cycles to wait for a pair-found pulse after the second selection.
REQ-003 clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 new_game  in  1  synchronous clear; same effect as reset.
REQ-006 sel_valid  in  1  one-cycle pulse: player confirmed the card at sel_loc.
REQ-007 sel_loc  in  6  selected cell index, 0..35 valid.
REQ-008 pair_found  in  1  one-cycle pulse from the pair comparator: the last two cards match.
REQ-009 pair_loc1, pair_loc2  in  6 each  cell indices of the matched pair, valid with pair_found.
REQ-010 rd_loc  in  6  display query address.
REQ-011 rd_state  out  2  combinational state of cell rd_loc: 0 HIDDEN, 1 REVEALED, 2 MATCHED; rd_loc>35 returns HIDDEN.
REQ-012 busy  out  1  high while selections are ignored (JUDGE or HOLD).
REQ-013 first_loc, second_loc  out  6 each  currently face-up unmatched cells; 6'h3F when unused.
REQ-014 matched_count  out  5  pairs matched, 0..18.
REQ-015 all_matched  out  1  high when matched_count==18.

Function
REQ-016 Per-cell state array of 36 x 2 bits; only this block writes it.
REQ-017 FSM states: IDLE, ONE_UP, JUDGE, HOLD.
REQ-018 IDLE: a sel_valid on a HIDDEN cell with sel_loc<=35 sets that cell REVEALED, sets first_loc=sel_loc, and goes to ONE_UP.
REQ-019 ONE_UP: a sel_valid on a different HIDDEN cell sets it REVEALED, sets second_loc, loads the wait counter with COMPARE_WAIT, and goes to JUDGE.
REQ-020 In IDLE and ONE_UP, a selection of a REVEALED, MATCHED, out-of-range, or same-as-first cell is ignored with no state change.
REQ-021 JUDGE: pair_found with {pair_loc1,pair_loc2} equal to {first_loc,second_loc} in either order sets both cells MATCHED, increments matched_count, clears first/second_loc to 3F, and goes to IDLE in the same edge.
REQ-022 JUDGE: when the wait counter expires with no qualifying pair_found, load the reveal counter with REVEAL_CYCLES-1 and go to HOLD.
REQ-023 HOLD: decrement each cycle; when it reaches 0, set both cells HIDDEN, clear first/second_loc, and go to IDLE.
REQ-024 pair_found outside JUDGE, or with non-matching locations, is ignored.
REQ-025 sel_valid during JUDGE or HOLD is dropped, not queued.
REQ-026 busy = (state==JUDGE || state==HOLD), registered with the state.
REQ-027 matched_count saturates at 18; once all_matched=1, all selections are ignored until reset or new_game.
REQ-028 Simultaneous new_game and any other input: new_game wins.

Reset
REQ-029 On reset or new_game: all cells HIDDEN, state IDLE, first_loc=second_loc=6'h3F, matched_count=0, all_matched=0, busy=0, counters=0.
REQ-030 Reset asserted mid-JUDGE or mid-HOLD aborts the operation, with no partial MATCHED update.

Structure
REQ-031 Shared package card_pkg holds cell_state_t (HIDDEN/REVEALED/MATCHED), the tracker FSM enum, NUM_CELLS=36, NUM_PAIRS=18, and NO_LOC=6'h3F.
REQ-032 The down-counter is one sub-module, reveal_timer (load, value, enable, zero flag), used for both the JUDGE wait and the HOLD countdown.

Verification (bench uses REVEAL_CYCLES=8, COMPARE_WAIT=4)
REQ-033 Match: select 3, then 17; pair_found(17,3) on JUDGE cycle 2 -> cells 3 and 17 MATCHED, matched_count=1, busy=0 next cycle, state IDLE.
REQ-034 Mismatch: select 5, then 9; no pair_found -> busy=1 for 4+8 cycles, then cells 5 and 9 HIDDEN, first_loc=second_loc=3F.
REQ-035 Ignored inputs: select 5 twice, select 40, select a MATCHED cell, sel_valid during HOLD -> no cell change; the state stays as it was.
REQ-036 Stray pair_found(1,2) while first=5, second=9 in JUDGE -> ignored, and the normal mismatch timeout follows.
REQ-037 Full game: 18 scripted matches -> matched_count=18, all_matched=1; a further sel_valid has no effect; new_game returns all outputs to reset values.
REQ-038 Reset asserted on HOLD cycle 3 -> all cells HIDDEN, IDLE, busy=0 immediately (asynchronous).
